dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder on the far end of the core's load/store interface: accepts one
//  request (mem_read/mem_write + funct3 + addr) via valid/ready, waits WAIT_STATES cycles,
//  performs the access on an internal word-organised RAM and returns a one-cycle response.
//  Handles LB/LH/LW/LBU/LHU and SB/SH/SW byte lanes; the core stalls until rsp_valid.
// PARAMETERS
//  DEPTH        1024  RAM size in 32-bit words (power of two); ADDR_W = $clog2(DEPTH) localparam
//  WAIT_STATES  1     extra cycles between acceptance and response (0..15)
// PORTS
//  clk        in   1   single clock, all logic rising-edge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder idle; request accepted when req_valid && req_ready
//  mem_read   in   1   load request (control-unit Memory_Read)
//  mem_write  in   1   store request (control-unit Memory_Write)
//  funct3     in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  addr       in   32  byte address
//  wdata      in   32  store data, right-aligned (byte in [7:0], half in [15:0])
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_rdata  out  32  load result, extended per funct3; 0 for stores/no-ops
//  rsp_err    out  1   misaligned access flag (valid with rsp_valid)
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0;
//    RAM contents not reset. Reset mid-operation aborts: uncommitted store is dropped.
//  - FSM IDLE -> WAIT (on accept; counter loaded with WAIT_STATES) -> RESP -> IDLE.
//    WAIT_STATES=0 skips WAIT (IDLE -> RESP). req_ready=1 only in IDLE.
//  - Latency: accept on edge N; rsp_valid high during cycle N+WAIT_STATES+1, exactly one cycle.
//    Throughput: one request per WAIT_STATES+2 cycles.
//  - addr, funct3, wdata, mem_read, mem_write latched at accept; inputs ignored otherwise.
//  - Word index = addr[ADDR_W+1:2]; higher address bits ignored (wraps modulo DEPTH*4).
//  - Store and read data capture both occur on the edge entering RESP.
//  - Loads: byte lane addr[1:0], half lane addr[1]; B/H sign-extend, BU/HU zero-extend, W as is.
//  - Stores: SB writes 1 byte lane, SH 2 lanes, SW all 4; unselected lanes unchanged.
//  - mem_read && mem_write both 1: store wins, rsp_rdata=0. Neither: no-op, rsp_rdata=0.
//  - Unsupported funct3 (011,110,111): treated as W.
// CONFIGURATION
//  MISALIGN_ERR_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 -> no RAM write,
//    rsp_rdata=0, rsp_err=1 in RESP cycle.
//  MISALIGN_ERR_EN undefined: address aligned down (low bits cleared for the access size),
//    access performed normally, rsp_err tied 0.
// STRUCTURE
//  Package rv_mem_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU), state enum
//    (ST_IDLE,ST_WAIT,ST_RESP), opcode constants shared with the control decoder.
//  Sub-module lsu_lane_align (combinational): byte-enable + store-data replication from
//    funct3/addr[1:0], and load extraction/extension from RAM word.
// TESTING
//  1 SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0.
//  2 SB 0x13 wdata 0x80 after (1); LB 0x13 -> 0xFFFFFF80; LBU 0x13 -> 0x00000080; LW 0x10 -> 0x80ADBEEF.
//  3 WAIT_STATES=3: accept at edge N -> rsp_valid only in cycle N+4; req_ready 0 cycles N+1..N+4.
//  4 LH 0x11 with MISALIGN_ERR_EN -> rsp_err 1, rdata 0, RAM unchanged; without -> reads half at 0x10.
//  5 Store accepted, rst_n pulsed low during WAIT -> rsp_valid never asserts, later LW shows old data.
//  6 SW addr (DEPTH*4)+0x4 0x12345678 -> LW 0x4 returns 0x12345678 (wrap); read+write both set -> write done.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared load/store definitions: funct3 codes, responder FSM states, request payload.
package rv_mem_pkg;

    // funct3 access size/sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Major opcodes shared with the control decoder
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Request fields latched at acceptance
    typedef struct packed {
        logic            mem_read;
        logic            mem_write;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    // Access size from funct3; unsupported codes fall through to word
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_B;
            2'b01:   return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the data memory: store byte enables / data replication and
// load lane extraction with sign or zero extension. Purely combinational.
// MISALIGN_ERR_EN: when defined, misaligned H/W accesses are flagged on misalign_c;
// otherwise the offset is silently aligned down and misalign_c stays 0.
module lsu_lane_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [3:0]      be_c,
    output logic [XLEN-1:0] wdata_rep_c,
    output logic [XLEN-1:0] rdata_c,
    output logic            misalign_c
);

    size_e       size;
    logic        sign_ext;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic        mis_raw;

    // Lane select, store replication and load extension for the decoded size
    always_comb begin
        size        = f3_size(funct3);
        sign_ext    = ~funct3[2];
        be_c        = 4'b0000;
        wdata_rep_c = '0;
        rdata_c     = '0;
        rbyte       = 8'h00;
        rhalf       = 16'h0000;
        mis_raw     = 1'b0;
        case (size)
            SZ_B: begin
                be_c        = 4'b0001 << addr_lo;
                wdata_rep_c = {4{wdata[7:0]}};
                rbyte       = rword[{addr_lo, 3'b000} +: 8];
                rdata_c     = sign_ext ? {{24{rbyte[7]}}, rbyte} : {24'h000000, rbyte};
            end
            SZ_H: begin
                mis_raw     = addr_lo[0];
                be_c        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep_c = {2{wdata[15:0]}};
                rhalf       = addr_lo[1] ? rword[31:16] : rword[15:0];
                rdata_c     = sign_ext ? {{16{rhalf[15]}}, rhalf} : {16'h0000, rhalf};
            end
            default: begin
                mis_raw     = |addr_lo;
                be_c        = 4'b1111;
                wdata_rep_c = wdata;
                rdata_c     = rword;
            end
        endcase
    end

`ifdef MISALIGN_ERR_EN
    assign misalign_c = mis_raw;
`else
    logic unused_mis_c;
    assign unused_mis_c = mis_raw;
    assign misalign_c   = 1'b0;
`endif

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store via valid/ready, waits WAIT_STATES
// cycles, accesses a word-organised RAM and returns a one-cycle response.
// MISALIGN_ERR_EN: when defined, misaligned H/HU/W accesses report rsp_err and
// leave the RAM untouched; when undefined they are aligned down and performed.
module dmem_responder
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err
);

    localparam int unsigned ADDR_W  = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_STATES);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    mem_req_t        req_q, req_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q, rsp_err_d;

    logic [XLEN-1:0] mem [DEPTH];

    mem_req_t        cur_req;
    logic [ADDR_W-1:0] word_idx;
    logic [XLEN-1:0] rword;
    logic            enter_resp_c;
    logic            is_store_c;
    logic            is_load_c;
    logic            ram_we_c;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] load_data;
    logic            misalign;
    logic            unused_addr_c;

    // Live inputs drive the access while idle (covers WAIT_STATES=0), latched copy afterwards
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_req.mem_read  = mem_read;
            cur_req.mem_write = mem_write;
            cur_req.funct3    = funct3;
            cur_req.addr      = addr;
            cur_req.wdata     = wdata;
        end else begin
            cur_req = req_q;
        end
        word_idx = cur_req.addr[ADDR_W+1:2];
        rword    = mem[word_idx];
    end

    assign unused_addr_c = ^cur_req.addr[XLEN-1:ADDR_W+2];

    lsu_lane_align u_lane (
        .funct3      (cur_req.funct3),
        .addr_lo     (cur_req.addr[1:0]),
        .wdata       (cur_req.wdata),
        .rword       (rword),
        .be_c        (be),
        .wdata_rep_c (wdata_rep),
        .rdata_c     (load_data),
        .misalign_c  (misalign)
    );

    // Next-state, wait counter, request latch and response outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_d        = req_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d = cur_req;
                    if (WAIT_LD == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        enter_resp_c = (state_d == ST_RESP) && (state_q != ST_RESP);
        is_store_c   = cur_req.mem_write;
        is_load_c    = cur_req.mem_read & ~cur_req.mem_write;

        req_ready_d  = (state_d == ST_IDLE);
        rsp_valid_d  = enter_resp_c;
        rsp_err_d    = enter_resp_c & misalign & (is_load_c | is_store_c);
        rsp_rdata_d  = (enter_resp_c && is_load_c && !misalign) ? load_data : '0;
        ram_we_c     = rst_n & enter_resp_c & is_store_c & ~misalign;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-enabled RAM write on the edge entering RESP; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-array memory model predicts each
// response at issue time; a negedge monitor pops and compares when rsp_valid is seen.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 3;
    localparam int unsigned BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mm [BYTES];

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: byte-addressed memory, access size from funct3, address modulo RAM size
    task automatic model(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] exp_rd, output logic exp_err);
        int unsigned nb;
        int unsigned ba;
        logic [31:0] v;
        nb = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        ba = a % BYTES;
        exp_rd  = '0;
        exp_err = 1'b0;
`ifdef MISALIGN_ERR_EN
        if ((rd || wr) && (ba % nb) != 0) begin
            exp_err = 1'b1;
            return;
        end
`endif
        ba = ba - (ba % nb);
        if (wr) begin
            for (int i = 0; i < int'(nb); i++) mm[ba + i] = wd[8*i +: 8];
        end else if (rd) begin
            v = '0;
            for (int i = 0; i < int'(nb); i++) v[8*i +: 8] = mm[ba + i];
            if (!f3[2] && nb == 1) v = {{24{v[7]}}, v[7:0]};
            if (!f3[2] && nb == 2) v = {{16{v[15]}}, v[15:0]};
            exp_rd = v;
        end
    endtask

    // Issue one request; optionally pulse reset during WAIT to abort it
    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input bit abort);
        int   t;
        exp_t e;
        t = 0;
        while (req_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        if (!abort) model(rd, wr, f3, a, wd, e.rdata, e.err);
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (!abort) exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        funct3    = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        if (abort) begin
            chk("busy_before_abort", 32'(req_ready), 32'd0);
            rst_n = 1'b0;
            #2;
            chk("ready_in_reset", 32'(req_ready), 32'd1);
            rst_n = 1'b1;
            @(negedge clk);
            return;
        end
        for (int k = 0; k <= int'(WS); k++) begin
            chk("ready_busy", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    // Monitor: every response must match the oldest outstanding prediction
    always @(negedge clk) begin
        if (rst_n && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(e.err));
                chk("rsp_latency", 32'(cyc - e.acc), 32'(WS));
            end
        end
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload the region used below so every load reads defined data
        for (int w = 0; w < 32; w++) issue(1'b0, 1'b1, 3'b010, 32'(w * 4), $urandom, 1'b0);

        issue(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 3'b000, 32'h13, 32'h80, 1'b0);
        issue(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b001, 32'h11, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);

        issue(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b1);
        issue(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);

        issue(1'b0, 1'b1, 3'b010, 32'(BYTES + 4), 32'h12345678, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h4, 32'h0, 1'b0);
        issue(1'b1, 1'b1, 3'b010, 32'h8, 32'hA5A5A5A5, 1'b0);
        issue(1'b1, 1'b0, 3'b010, 32'h8, 32'h0, 1'b0);
        issue(1'b0, 1'b0, 3'b010, 32'hC, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 3'b111, 32'hC, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 127)) + 32'($urandom_range(0, 3) * BYTES);
            issue(1'($urandom), 1'($urandom), 3'($urandom), a, $urandom, 1'b0);
        end

        t = 0;
        while (exp_q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("outstanding_at_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
